// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the restoring divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Iteration counter runs 0..width-1; width >= 2 keeps this at least one bit.
    function automatic int cnt_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_subtractor.sv
// rtl/ripple_subtractor.sv - X - Y as X + ~Y + 1 over a chain of full adders
module ripple_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         carry_out
);

    logic [N:0] carry;

    // Carry-in of one completes the two's complement of y; carry-out 1 means no borrow.
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            full_adder u_fa (
                .a    (x[i]),
                .b    (~y[i]),
                .cin  (carry[i]),
                .sum  (diff[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    assign carry_out = carry[N];

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = cnt_bits(WIDTH);

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             take_sub;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    assign a_shift = {a[WIDTH-1:0], q[WIDTH-1]};

    ripple_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .x         (a_shift),
        .y         (m),
        .diff      (diff),
        .carry_out (no_borrow)
    );

    // a[WIDTH] is zero after every restore; folding it in keeps the step exact for any A.
    assign take_sub = no_borrow | a[WIDTH];
    assign a_next   = take_sub ? diff : a_shift;
    assign q_next   = {q[WIDTH-2:0], take_sub};

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            a         <= '0;
            m         <= '0;
            q         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (Divisor == '0) begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                            state     <= DONE;
                        end else begin
                            a     <= '0;
                            q     <= Dividend;
                            m     <= {1'b0, Divisor};
                            cnt   <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    a   <= a_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        Quotient  <= q_next;
                        Remainder <= a_next[WIDTH-1:0];
                        DivByZero <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned restoring divider: one quotient bit per clock, using a ripple subtract-and-test datapath.
- It is the inverse companion to the ripple adder datapath, using the same full_adder cells with an inverted operand and carry-in 1.
- Started by a one-cycle handshake; results are held until the next accepted Start.
- Used by lab datapaths that need integer division and remainder without a combinational divider.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Dividend  input  WIDTH  unsigned dividend; sampled on the accepting edge.
- Divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge.
- Quotient  output  WIDTH  registered quotient.
- Remainder  output  WIDTH  registered remainder.
- Busy  output  1  high while the iteration is in progress (RUN).
- Done  output  1  one-cycle pulse when Quotient/Remainder become valid.
- DivByZero  output  1  registered flag for the last accepted operation; valid with Done.

Behaviour:
- Reset (Reset_n low, asynchronous, regardless of state):
  - state = IDLE.
  - Quotient, Remainder, Busy, Done, DivByZero = 0.
  - Internal A, Q, M and counter = 0.
  - Any operation in flight is abandoned; no Done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start = 0: remain in IDLE.
  - Start = 1 and Divisor != 0 (edge E0): A (WIDTH+1 bits) = 0, Q = Dividend, M = {0, Divisor}, cnt = 0, go to RUN.
  - Start = 1 and Divisor == 0:
    - Quotient = all ones.
    - Remainder = Dividend.
    - DivByZero = 1.
    - Go to DONE (Done is high the cycle after E0).
- RUN (edges E1..E_WIDTH):
  - Shift {A,Q} left one bit to form A' and Q'.
  - T = A' - M via the subtractor.
  - No borrow (subtractor carry-out = 1): A = T, Q = {Q'[WIDTH-1:1], 1}.
  - Borrow: A = A', Q = {Q'[WIDTH-1:1], 0}.
  - cnt increments each edge.
  - On the edge where cnt == WIDTH-1 (edge E_WIDTH):
    - Quotient = final Q.
    - Remainder = final A[WIDTH-1:0].
    - DivByZero = 0.
    - Go to DONE.
- DONE: Done = 1 for exactly this cycle; next edge returns to IDLE. Start is ignored in DONE.
- Outputs Busy and Done are decoded from the state register (Moore), glitch-free.
- Latency (normal case):
  - Busy is high for WIDTH cycles.
  - Done is high in the cycle after edge E_WIDTH.
  - Accept-to-Done = WIDTH+1 cycles.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- Start while Busy or Done is ignored. Inputs may change freely after E0 without effect.
- Quotient/Remainder/DivByZero change only on the completion edge and hold until the next completion or reset.
- Width and arithmetic rules:
  - All arithmetic is unsigned.
  - A is WIDTH+1 bits so the shifted partial remainder never overflows.
  - The final remainder is always < Divisor and fits in WIDTH bits.
  - Dividend = 0 gives Q = 0, R = 0 after full latency.
  - Divisor > Dividend gives Q = 0, R = Dividend.
- Invariant for verification: Quotient*Divisor + Remainder == Dividend whenever DivByZero = 0.

Decomposition:
- Package div_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Localparam for the counter width, $clog2(WIDTH).
- Sub-module ripple_subtractor #(N = WIDTH+1):
  - Computes X - Y as X + ~Y + 1.
  - Built from a generate chain of the existing full_adder cell.
  - Outputs difference and carry-out (1 = no borrow).
- The divider instantiates one ripple_subtractor; the FSM, shift registers and counter stay in restoring_divider.

Test Plan:
- Dividend=100, Divisor=7, Start for 1 cycle -> Busy high 8 cycles; Done pulse 9 cycles after accept; Quotient=14, Remainder=2, DivByZero=0.
- Dividend=255, Divisor=1 -> Quotient=255, Remainder=0; then Dividend=255, Divisor=255 -> Quotient=1, Remainder=0.
- Dividend=5, Divisor=9 -> Quotient=0, Remainder=5; Dividend=0, Divisor=3 -> Quotient=0, Remainder=0 after full latency.
- Dividend=77, Divisor=0 -> Done the cycle after accept, Quotient=8'hFF, Remainder=77, DivByZero=1, Busy never high.
- Start 200/13, drop Reset_n at cycle 4 of RUN -> all outputs 0 immediately; no Done; after release, 200/13 -> Quotient=15, Remainder=5.
- Start 100/7, pulse Start again with 50/5 at cycle 3 of RUN and during DONE -> both ignored; result 14/2; next Start in IDLE gives 10/0. Then run 1000 random operand pairs checking the invariant.
